// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   localparam int SUB_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow-out for a single bit position
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: result = (in_a - in_b) mod 2^WIDTH, LSB first,
// one bit per clock through a registered borrow, with start/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; operands latched on an accepted start
//   RUN   | one bit per cycle; busy high; last bit when cnt == WIDTH-1
//   DONE  | done pulses for one cycle, result/borrow valid
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] result,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   sub_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   // Holds the WIDTH-1 difference bits produced so far, MSB-aligned.
   logic [WIDTH-2:0] res_sr;
   logic             br;
   logic             d_bit;
   logic             bout_bit;
   logic [WIDTH-1:0] res_next;

   full_subtractor u_fs (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (bout_bit)
   );

   // Newest difference bit enters at the MSB; on the last bit this is the full result
   always_comb begin
      res_next = {d_bit, res_sr};
   end

   // Control FSM, datapath shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         result <= '0;
         borrow <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= in_a;
                  b_sr  <= in_b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next[WIDTH-1:1];
               br     <= bout_bit;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  result <= res_next;
                  borrow <= bout_bit;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W-1:0] result;
   logic         borrow;
   logic         busy;
   logic         done;

   int passed = 0;
   int total  = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .in_a   (in_a),
      .in_b   (in_b),
      .result (result),
      .borrow (borrow),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive a start pulse sampled at the next-but-one rising edge (E0); returns #1 after E0.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk);
      #1;
      in_a  = a;
      in_b  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called #1 after E0. lat = cycle index (1 = cycle after E0) at which done is seen.
   task automatic wait_done(output int lat, output int busy_n, output int overlap);
      lat     = 0;
      busy_n  = 0;
      overlap = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (busy && done) overlap++;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_r, input logic exp_b);
      int lat, bn, ov;
      start_op(a, b);
      wait_done(lat, bn, ov);
      check({tag, "_latency"}, lat, 9);
      check({tag, "_busy_cycles"}, bn, 8);
      check({tag, "_overlap"}, ov, 0);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_borrow"}, borrow, exp_b);
      @(negedge clk);
      check({tag, "_done_pulse_end"}, done, 1'b0);
   endtask

   initial begin
      int lat, bn, ov, seen_done, seen_busy;
      rst   = 1'b1;
      start = 1'b0;
      in_a  = '0;
      in_b  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_result", result, 8'h00);
      check("reset_borrow", borrow, 1'b0);
      check("reset_busy",   busy,   1'b0);
      check("reset_done",   done,   1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      run_op("eq_0a_0a",  8'h0A, 8'h0A, 8'h00, 1'b0);
      run_op("wrap_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);

      // FF-FF: prior result/borrow must hold during RUN
      start_op(8'hFF, 8'hFF);
      @(negedge clk);
      check("hold_result_in_run", result, 8'hFF);
      check("hold_borrow_in_run", borrow, 1'b1);
      check("busy_after_e0", busy, 1'b1);
      wait_done(lat, bn, ov);
      check("ff_ff_latency", lat, 8);
      check("ff_ff_result", result, 8'h00);
      check("ff_ff_borrow", borrow, 1'b0);

      run_op("sub_0a_03", 8'h0A, 8'h03, 8'h07, 1'b0);

      // start held high, operands change during RUN
      @(posedge clk);
      #1;
      in_a  = 8'h0A;
      in_b  = 8'h03;
      start = 1'b1;
      @(posedge clk);
      #1;
      in_a = 8'h55;
      in_b = 8'h11;
      wait_done(lat, bn, ov);
      check("held_first_latency", lat, 9);
      check("held_first_result", result, 8'h07);
      @(posedge clk);
      #1;
      check("held_idle_after_done", busy, 1'b0);
      @(posedge clk);
      #1;
      check("held_second_accepted", busy, 1'b1);
      start = 1'b0;
      wait_done(lat, bn, ov);
      check("held_second_latency", lat, 9);
      check("held_second_result", result, 8'h44);
      check("held_second_borrow", borrow, 1'b0);

      run_op("wrap2_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);

      // reset during RUN bit 4 of 80-01
      start_op(8'h80, 8'h01);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_result", result, 8'h00);
      check("midrst_borrow", borrow, 1'b0);
      check("midrst_busy",   busy,   1'b0);
      check("midrst_done",   done,   1'b0);
      seen_done = 0;
      seen_busy = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen_done++;
         if (busy) seen_busy++;
      end
      check("midrst_no_done", seen_done, 0);
      check("midrst_stays_idle", seen_busy, 0);

      run_op("fresh_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);

      // simultaneous rst and start: start dropped
      @(posedge clk);
      #1;
      in_a  = 8'h10;
      in_b  = 8'h01;
      start = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);
      check("rst_start_busy", busy, 1'b0);
      check("rst_start_result", result, 8'h00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial WIDTH-bit subtractor computing `in_a - in_b` one bit per clock, LSB first, through a registered borrow chain. It is the inverse counterpart of the lab's combinational adder and uses the same operand and result widths. It adds a start/done handshake so that students can observe multi-cycle datapath behaviour, and can be driven directly from switches and LEDs on the Nexys 4 board.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk` in 1: system clock. All state updates occur on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a subtraction. Sampled only in IDLE.
- `in_a` in WIDTH: minuend. Latched on an accepted `start`.
- `in_b` in WIDTH: subtrahend. Latched on an accepted `start`.
- `result` out WIDTH: difference `(in_a - in_b) mod 2^WIDTH`.
- `borrow` out 1: high when `in_a < in_b` (unsigned), i.e. the final borrow-out.
- `busy` out 1: high while bits are being processed (RUN state).
- `done` out 1: one-cycle pulse that marks `result`/`borrow` as valid.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - On `start=1`, latch `in_a` and `in_b` into internal shift registers, clear the borrow flop, clear the bit counter, and go to RUN.
  - On `start=0`, stay in IDLE.
- **RUN, each cycle:**
  - Take the operand LSBs `a_i` and `b_i`.
  - `d = a_i ^ b_i ^ br`.
  - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`.
  - Shift `d` into the MSB of the result shift register (right shift).
  - Shift both operand registers right.
  - Increment the counter.
  - When the counter reaches WIDTH-1, this is the last bit. Go to DONE and register `borrow` from `br_next`.
- **DONE:** assert `done` for one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. It is not queued.
- Operand inputs may change freely after the accepting edge.
- `result` and `borrow` change only at the edge that enters DONE. They hold their values until the next completion or reset.
- Arithmetic is unsigned modulo 2^WIDTH. There is no sign or overflow flag.
- Reset values: `result=0`, `borrow=0`, `busy=0`, `done=0`, state IDLE, counter 0.
- Reset mid-operation (RUN or DONE):
  - Return to IDLE.
  - Clear all outputs.
  - The partial result is discarded and never appears on `result`.
- Simultaneous `rst` and `start`: reset wins and the start is dropped.

## Timing
- Edge E0 is the edge at which `start` is sampled high in IDLE.
- `busy` is high in the cycles following edges E0 through E(WIDTH-1), i.e. WIDTH cycles.
- Edge E(WIDTH) enters DONE. `done=1` and the final `result`/`borrow` are visible in the cycle after E(WIDTH).
- Edge E(WIDTH+1) returns to IDLE. `done=0`.
- A new `start` can be accepted at E(WIDTH+2) at the earliest, so throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `serial_sub_pkg` holds:
  - the state enum `sub_state_t {IDLE, RUN, DONE}`;
  - the default width constant `SUB_WIDTH = 8`.
- Sub-module `full_subtractor`: purely combinational, inputs `a`, `b`, `bin`, outputs `d`, `bout`. It is instantiated once in the serial datapath.
- Top level contains the FSM, the counter of `$clog2(WIDTH)` bits, the operand and result shift registers, and the borrow flop.

## Test plan
- Reset, then `start` with A=8'h0A, B=8'h0A → `done` pulses 9 cycles after the `start` edge; `result=8'h00`, `borrow=0`.
- A=8'h00, B=8'h01 → `result=8'hFF`, `borrow=1`. Then A=8'hFF, B=8'hFF → `result=8'h00`, `borrow=0`.
- A=8'h0A, B=8'h03 → `result=8'h07`, `borrow=0`; `busy` is high for exactly 8 cycles.
- Hold `start` high for the whole operation, with operands changed to A=8'h55, B=8'h11 during RUN:
  - the first result is from the originally latched operands;
  - the next op is accepted only after `done`, and gives `result=8'h44`.
- Assert `rst` for 1 cycle at RUN bit 4 of A=8'h80, B=8'h01 → all outputs are 0 and the FSM is in IDLE; no `done` pulse follows. A fresh start then yields `result=8'h7F`.
